// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer for an external 1-bit ALU slice: runs one operand bit per cycle, LSB first.
// Optional feature: define ALU_SEQ_ABORT_EN to add an `abort` input that cancels an op in RUN/DONE.
module alu_serial_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
`ifdef ALU_SEQ_ABORT_EN
   input  logic             abort,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero,
   output logic [2:0]       sl_sel,
   output logic             sl_a,
   output logic             sl_b,
   output logic             sl_cin,
   output logic             sl_invta,
   output logic             sl_invtb,
   input  logic             sl_result,
   input  logic             sl_cout,
   input  logic             sl_ovf
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_SLT  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_NAND = 3'b101;
   localparam logic [2:0] OP_NOR  = 3'b110;
   localparam logic [2:0] OP_OR   = 3'b111;

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-2:0] res_q;

   logic       run;
   logic       last;
   logic       abort_hit;
   logic       is_arith;
   logic [2:0] dec_sel;
   logic       dec_invta;
   logic       dec_invtb;

`ifdef ALU_SEQ_ABORT_EN
   assign abort_hit = abort;
`else
   assign abort_hit = 1'b0;
`endif

   assign run       = (state == S_RUN);
   assign last      = (cnt == CW'(WIDTH - 1));
   assign is_arith  = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT);
   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign out_zero  = (out_result == '0);

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      dec_sel   = op_q;
      dec_invta = 1'b0;
      dec_invtb = 1'b0;
      case (op_q)
         OP_SUB, OP_SLT: dec_invtb = 1'b1;
         OP_AND, OP_OR: begin
            dec_invta = 1'b1;
            dec_invtb = 1'b1;
         end
         OP_ADD, OP_XOR, OP_NAND, OP_NOR: ;
         default: ;
      endcase
   end

   // The slice only ever sees a live operation; outside RUN everything is held at 0.
   assign sl_sel   = run ? dec_sel : 3'b000;
   assign sl_invta = run & dec_invta;
   assign sl_invtb = run & dec_invtb;
   assign sl_a     = run & a_q[0];
   assign sl_b     = run & b_q[0];
   assign sl_cin   = run & carry;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         carry      <= 1'b0;
         op_q       <= OP_ADD;
         a_q        <= '0;
         b_q        <= '0;
         res_q      <= '0;
         out_result <= '0;
         out_cout   <= 1'b0;
         out_ovf    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  state <= S_RUN;
                  op_q  <= in_op;
                  a_q   <= in_a;
                  b_q   <= in_b;
                  cnt   <= '0;
                  carry <= (in_op == OP_SUB) || (in_op == OP_SLT);
               end
            end
            S_RUN: begin
               if (abort_hit) begin
                  state <= S_IDLE;
                  cnt   <= '0;
                  carry <= 1'b0;
               end else begin
                  a_q   <= a_q >> 1;
                  b_q   <= b_q >> 1;
                  carry <= sl_cout;
                  if (last) begin
                     state    <= S_DONE;
                     cnt      <= '0;
                     carry    <= 1'b0;
                     out_cout <= is_arith & sl_cout;
                     out_ovf  <= ((op_q == OP_ADD) || (op_q == OP_SUB)) & sl_ovf;
                     // SLT sign is sum MSB corrected by overflow, i.e. the true sign of a-b.
                     if (op_q == OP_SLT)
                        out_result <= {{(WIDTH-1){1'b0}}, sl_result ^ sl_ovf};
                     else
                        out_result <= {sl_result, res_q};
                  end else begin
                     res_q[cnt] <= sl_result;
                     cnt        <= cnt + CW'(1);
                  end
               end
            end
            S_DONE: begin
               if (abort_hit || out_ready)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl (WIDTH=8): attached slice model, arithmetic reference
// model with scoreboard queue, literal directed cases, backpressure, reset and random traffic.
module tb_alu_serial_ctrl;

   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] res;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset;
`ifdef ALU_SEQ_ABORT_EN
   logic         abort;
`endif
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   in_op;
   logic [W-1:0] in_a, in_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_result;
   logic         out_cout, out_ovf, out_zero;
   logic [2:0]   sl_sel;
   logic         sl_a, sl_b, sl_cin, sl_invta, sl_invtb;
   logic         sl_result, sl_cout, sl_ovf;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alu_serial_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset),
`ifdef ALU_SEQ_ABORT_EN
      .abort(abort),
`endif
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero),
      .sl_sel(sl_sel), .sl_a(sl_a), .sl_b(sl_b), .sl_cin(sl_cin),
      .sl_invta(sl_invta), .sl_invtb(sl_invtb),
      .sl_result(sl_result), .sl_cout(sl_cout), .sl_ovf(sl_ovf)
   );

   // 1-bit slice: operands optionally inverted, then adder (000/001/011), XOR (010),
   // NOR (100/110) or NAND (101/111); so AND/OR come from inverted NOR/NAND.
   always_comb begin
      logic av, bv;
      av        = sl_a ^ sl_invta;
      bv        = sl_b ^ sl_invtb;
      sl_result = 1'b0;
      sl_cout   = 1'b0;
      sl_ovf    = 1'b0;
      case (sl_sel)
         3'b000, 3'b001, 3'b011: begin
            sl_result = av ^ bv ^ sl_cin;
            sl_cout   = (av & bv) | (sl_cin & (av ^ bv));
            sl_ovf    = sl_cin ^ sl_cout;
         end
         3'b010:         sl_result = av ^ bv;
         3'b100, 3'b110: sl_result = ~(av | bv);
         default:        sl_result = ~(av & bv);
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model straight from the op definitions.
   function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t   e;
      logic [W:0] s;
      e = '0;
      case (op)
         3'b000: begin
            s = {1'b0, a} + {1'b0, b};
            e.res = s[W-1:0]; e.cout = s[W];
            e.ovf = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
         end
         3'b001: begin
            s = {1'b0, a} + {1'b0, ~b} + 1;
            e.res = s[W-1:0]; e.cout = s[W];
            e.ovf = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
         end
         3'b011: begin
            e.res  = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            e.cout = (a >= b);
         end
         3'b010: e.res = a ^ b;
         3'b100: e.res = a & b;
         3'b101: e.res = ~(a & b);
         3'b110: e.res = ~(a | b);
         default: e.res = a | b;
      endcase
      return e;
   endfunction

   // Scoreboard: every accepted op queues its expectation; outputs are checked on every
   // DONE cycle, plus latency and idle slice outputs.
   exp_t exp_q[$];
   int   cyc = 0;
   int   acc_cyc = 0;
   logic prev_valid = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         exp_q.delete();
         prev_valid = 1'b0;
      end else begin
         if (in_ready)
            check("idle_sl_zero", {26'd0, sl_sel, sl_a, sl_b, sl_cin, sl_invta, sl_invtb}, 32'd0);
         if (in_valid && in_ready) begin
            exp_q.push_back(model(in_op, in_a, in_b));
            acc_cyc = cyc;
         end
         if (out_valid) begin
            if (!prev_valid) check("mon_latency", cyc - acc_cyc, W + 1);
            if (exp_q.size() == 0) begin
               check("mon_unexpected_valid", 32'd1, 32'd0);
            end else begin
               check("mon_result", out_result, exp_q[0].res);
               check("mon_cout", out_cout, exp_q[0].cout);
               check("mon_ovf", out_ovf, exp_q[0].ovf);
               check("mon_zero", out_zero, exp_q[0].res == 0);
               if (out_ready) void'(exp_q.pop_front());
            end
         end
         prev_valid = out_valid;
      end
   end

   task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      bit done = 0;
      in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (in_ready) done = 1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!done) check("send_timeout", 32'd1, 32'd0);
   endtask

   task automatic get_result(input bit rnd, output logic [W-1:0] r, output logic c,
                             output logic o, output logic z, output int n);
      bit got = 0;
      r = '0; c = 0; o = 0; z = 0; n = 0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         n++;
         if (out_valid && out_ready) begin
            r = out_result; c = out_cout; o = out_ovf; z = out_zero; got = 1;
         end
         @(posedge clk); #1;
         if (rnd) out_ready = 1'($urandom_range(0, 1));
      end
      out_ready = 1'b1;
      if (!got) check("result_timeout", 32'd1, 32'd0);
   endtask

   task automatic run_lit(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] er, input logic ec,
                          input logic eo, input logic ez);
      logic [W-1:0] r;
      logic c, o, z;
      int n;
      send(op, a, b);
      get_result(0, r, c, o, z, n);
      check({name, "_res"}, r, er);
      check({name, "_flags"}, {c, o, z}, {ec, eo, ez});
   endtask

   task automatic reset_midrun(input bit use_abort);
      send(3'b000, 8'hFF, 8'hFF);
      repeat (3) @(posedge clk);
      #1;
`ifdef ALU_SEQ_ABORT_EN
      if (use_abort) abort = 1'b1; else reset = 1'b1;
`else
      reset = 1'b1;
`endif
      @(posedge clk); #1;
      reset = 1'b0;
`ifdef ALU_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      @(negedge clk);
      check("cancel_in_ready", in_ready, 1'b1);
      check("cancel_out_valid", out_valid, 1'b0);
      if (!use_abort) check("cancel_zero", {out_result, out_zero}, {8'h00, 1'b1});
      @(posedge clk); #1;
      run_lit("cancel_add11", 3'b000, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [W-1:0] r;
      logic c, o, z;
      int n;
      bit done;

      reset = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
`ifdef ALU_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_handshake", {in_ready, out_valid}, 2'b10);
      check("rst_outputs", {out_result, out_cout, out_ovf, out_zero}, {8'h00, 3'b001});
      check("rst_sl", {sl_sel, sl_a, sl_b, sl_cin, sl_invta, sl_invtb}, 8'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // ADD with explicit latency measurement
      send(3'b000, 8'h7F, 8'h01);
      get_result(0, r, c, o, z, n);
      check("add_latency", n, W + 1);
      check("add_res", r, 8'h80);
      check("add_flags", {c, o, z}, 3'b010);

      run_lit("sub_eq", 3'b001, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1);
      run_lit("sub_wrap", 3'b001, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0);
      run_lit("slt_neg", 3'b011, 8'h80, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0);
      run_lit("slt_pos", 3'b011, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1);
      run_lit("slt_eq", 3'b011, 8'h33, 8'h33, 8'h00, 1'b1, 1'b0, 1'b1);
      run_lit("and", 3'b100, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
      run_lit("or", 3'b111, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0);
      run_lit("xor", 3'b010, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0, 1'b0);
      run_lit("nand", 3'b101, 8'hF0, 8'h3C, 8'hCF, 1'b0, 1'b0, 1'b0);
      run_lit("nor", 3'b110, 8'hF0, 8'h3C, 8'h03, 1'b0, 1'b0, 1'b0);
      run_lit("sub_ovf", 3'b001, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);

      // Backpressure: result held for 5 cycles, second request stalled until IDLE
      out_ready = 1'b0;
      send(3'b000, 8'h10, 8'h20);
      done = 0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (out_valid) done = 1;
      end
      check("bp_valid_seen", done, 1'b1);
      @(posedge clk); #1;
      in_op = 3'b010; in_a = 8'hAA; in_b = 8'h0F; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold", {out_valid, in_ready, out_result}, {2'b10, 8'h30});
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_take_no_accept", {out_valid, in_ready}, 2'b10);
      @(negedge clk);
      check("bp_idle_accept", {out_valid, in_ready}, 2'b01);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_running", in_ready, 1'b0);
      @(posedge clk); #1;
      get_result(0, r, c, o, z, n);
      check("bp_second_res", r, 8'hA5);

      reset_midrun(0);
`ifdef ALU_SEQ_ABORT_EN
      reset_midrun(1);
`endif

      // Random traffic with random gaps and random consumer stalls
      for (int k = 0; k < 150; k++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
         get_result(1, r, c, o, z, n);
      end

      repeat (3) @(posedge clk);
      check("final_queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
